// File: rtl/tlc_lamp_monitor.sv
// tlc_lamp_monitor
// Lamp-side conflict monitor for the traffic light controller. Every clock
// it samples the six lamp drives and checks one-hot lamps, right-of-way
// conflicts, G->Y->R->G ordering and min/max dwell times. The first
// violation latches a fault code and raises flash_red. The latch is held
// until reset or a fault_clr pulse.
//
// Optional feature macro: MON_STUCK_EN. When defined, a green held for
// MAX_GREEN+1 samples raises code 13 (highway) or 14 (country). When it is
// undefined, green hold time is unbounded.
//
// Ports:
//   clk          system clock, shared with the controller
//   reset        synchronous, active-high
//   Gh/Yh/Rh     highway green/yellow/red lamp drives
//   Gc/Yc/Rc     country green/yellow/red lamp drives
//   fault_clr    one-cycle pulse; clears a latched fault and re-arms
//   armed        high while the monitor is in RUN
//   fault        latched fault flag
//   fault_code   code of the first fault (0 = none)
//   flash_red    lamp override request (same as fault)
//   cycles_done  completed highway cycles (highway Y->R), wraps at 16 bits
module tlc_lamp_monitor #(
  parameter int MIN_GREEN   = 4,
  parameter int MIN_YELLOW  = 1,
  parameter int MAX_YELLOW  = 4,
  parameter int ALL_RED_MIN = 0,
`ifdef MON_STUCK_EN
  parameter int MAX_GREEN   = 64,
`endif
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Gh,
  input  logic        Yh,
  input  logic        Rh,
  input  logic        Gc,
  input  logic        Yc,
  input  logic        Rc,
  input  logic        fault_clr,
  output logic        armed,
  output logic        fault,
  output logic [3:0]  fault_code,
  output logic        flash_red,
  output logic [15:0] cycles_done
);

  typedef enum logic [1:0] {L_R, L_G, L_Y, L_BAD} lamp_t;
  typedef enum logic [1:0] {S_ARM, S_RUN, S_FAULT} state_t;

  localparam logic [CNT_W-1:0] MIN_G_C  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y_C  = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_Y_C  = CNT_W'(MAX_YELLOW);
  localparam logic [CNT_W-1:0] AR_MIN_C = CNT_W'(ALL_RED_MIN);
`ifdef MON_STUCK_EN
  localparam logic [CNT_W-1:0] MAX_G_C  = CNT_W'(MAX_GREEN);
`endif

  function automatic lamp_t decode(input logic g, input logic y, input logic r);
    case ({g, y, r})
      3'b001:  decode = L_R;
      3'b100:  decode = L_G;
      3'b010:  decode = L_Y;
      default: decode = L_BAD;
    endcase
  endfunction

  function automatic logic legal_step(input lamp_t from, input lamp_t to);
    legal_step = (from == L_R && to == L_G) ||
                 (from == L_G && to == L_Y) ||
                 (from == L_Y && to == L_R);
  endfunction

  state_t           state;
  lamp_t            st_h, st_c, prev_h, prev_c;
  logic [CNT_W-1:0] cnt_h, cnt_c, cnt_h_nxt, cnt_c_nxt;
  // first_* marks the interval captured at arming, whose start time is
  // unknown, so minimum-dwell checks on leaving it are skipped.
  logic             first_h, first_c;
  logic             chg_h, chg_c;
  logic             arm_ok;
  logic [14:1]      viol;
  logic [3:0]       code_nxt;

  assign st_h   = decode(Gh, Yh, Rh);
  assign st_c   = decode(Gc, Yc, Rc);
  assign chg_h  = (st_h != prev_h);
  assign chg_c  = (st_c != prev_c);
  assign arm_ok = (st_h != L_BAD) && (st_c != L_BAD) &&
                  ((st_h == L_R) || (st_c == L_R));

  // Dwell including the current sample; restarts at 1 on a lamp change.
  assign cnt_h_nxt = chg_h ? CNT_W'(1) : ((&cnt_h) ? cnt_h : cnt_h + 1'b1);
  assign cnt_c_nxt = chg_c ? CNT_W'(1) : ((&cnt_c) ? cnt_c : cnt_c + 1'b1);

  always_comb begin
    viol = '0;
    // Conflict is judged on the red lamps themselves so a malformed triple
    // with its red lit reports as BAD rather than as a conflict.
    viol[1]  = !Rh && !Rc;
    viol[2]  = (st_h == L_BAD);
    viol[3]  = (st_c == L_BAD);
    viol[4]  = (st_h != L_BAD) && chg_h && !legal_step(prev_h, st_h);
    viol[5]  = (st_c != L_BAD) && chg_c && !legal_step(prev_c, st_c);
    viol[6]  = !first_h && prev_h == L_G && st_h == L_Y && cnt_h < MIN_G_C;
    viol[7]  = !first_c && prev_c == L_G && st_c == L_Y && cnt_c < MIN_G_C;
    viol[8]  = !chg_h && st_h == L_Y && cnt_h_nxt > MAX_Y_C;
    viol[9]  = !chg_c && st_c == L_Y && cnt_c_nxt > MAX_Y_C;
    viol[10] = !first_h && prev_h == L_Y && st_h == L_R && cnt_h < MIN_Y_C;
    viol[11] = !first_c && prev_c == L_Y && st_c == L_R && cnt_c < MIN_Y_C;
    // All-red gap: the other approach's red dwell counts from its Y->R
    // sample (dwell 1), so a gap of k samples shows as dwell k+1.
    if (ALL_RED_MIN > 0) begin
      viol[12] = (prev_h == L_R && st_h == L_G && st_c == L_R &&
                  (chg_c || !first_c) && cnt_c_nxt <= AR_MIN_C) ||
                 (prev_c == L_R && st_c == L_G && st_h == L_R &&
                  (chg_h || !first_h) && cnt_h_nxt <= AR_MIN_C);
    end
`ifdef MON_STUCK_EN
    viol[13] = !chg_h && st_h == L_G && cnt_h_nxt > MAX_G_C;
    viol[14] = !chg_c && st_c == L_G && cnt_c_nxt > MAX_G_C;
`endif
  end

  // Lowest set code wins: scan downward so the last hit is the smallest.
  always_comb begin
    code_nxt = 4'd0;
    for (int i = 14; i >= 1; i--)
      if (viol[i]) code_nxt = 4'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_ARM;
      armed       <= 1'b0;
      fault       <= 1'b0;
      flash_red   <= 1'b0;
      fault_code  <= 4'd0;
      cycles_done <= 16'd0;
      cnt_h       <= '0;
      cnt_c       <= '0;
      prev_h      <= L_R;
      prev_c      <= L_R;
      first_h     <= 1'b1;
      first_c     <= 1'b1;
    end else begin
      case (state)
        S_ARM: begin
          if (arm_ok) begin
            state   <= S_RUN;
            armed   <= 1'b1;
            prev_h  <= st_h;
            prev_c  <= st_c;
            cnt_h   <= '0;
            cnt_c   <= '0;
            first_h <= 1'b1;
            first_c <= 1'b1;
          end
        end
        S_RUN: begin
          if (|viol) begin
            state      <= S_FAULT;
            armed      <= 1'b0;
            fault      <= 1'b1;
            flash_red  <= 1'b1;
            fault_code <= code_nxt;
          end else begin
            prev_h  <= st_h;
            prev_c  <= st_c;
            cnt_h   <= cnt_h_nxt;
            cnt_c   <= cnt_c_nxt;
            first_h <= first_h & ~chg_h;
            first_c <= first_c & ~chg_c;
            if (prev_h == L_Y && st_h == L_R)
              cycles_done <= cycles_done + 16'd1;
          end
        end
        S_FAULT: begin
          if (fault_clr) begin
            state      <= S_ARM;
            fault      <= 1'b0;
            flash_red  <= 1'b0;
            fault_code <= 4'd0;
          end
        end
        default: state <= S_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// tb_tlc_lamp_monitor
// Directed bench for tlc_lamp_monitor. The driver applies one lamp sample
// per clock and queues the outputs expected after that clock; a separate
// monitor pops one entry per clock and compares.
module tb_tlc_lamp_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Gh = 1'b0, Yh = 1'b0, Rh = 1'b1;
  logic        Gc = 1'b0, Yc = 1'b0, Rc = 1'b1;
  logic        fault_clr = 1'b0;
  logic        armed, fault, flash_red;
  logic [3:0]  fault_code;
  logic [15:0] cycles_done;

  tlc_lamp_monitor dut (
    .clk(clk), .reset(reset),
    .Gh(Gh), .Yh(Yh), .Rh(Rh), .Gc(Gc), .Yc(Yc), .Rc(Rc),
    .fault_clr(fault_clr),
    .armed(armed), .fault(fault), .fault_code(fault_code),
    .flash_red(flash_red), .cycles_done(cycles_done)
  );

  always #5 clk = ~clk;

  // Lamp triples as {G,Y,R}
  localparam logic [2:0] LG = 3'b100, LY = 3'b010, LR = 3'b001, LBAD = 3'b011;

  typedef struct {
    string       tag;
    logic        armed;
    logic        fault;
    logic [3:0]  code;
    logic [15:0] cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cyc = 16'd0;
  string       phase = "reset";

  task automatic step(input logic [2:0] h, input logic [2:0] c,
                      input logic rst, input logic clr,
                      input logic ea, input logic ef, input logic [3:0] ec,
                      input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      {Gh, Yh, Rh} = h;
      {Gc, Yc, Rc} = c;
      reset        = rst;
      fault_clr    = clr;
      q.push_back('{phase, ea, ef, ec, exp_cyc});
    end
  endtask

  // Monitor: runs at the negedge before the driver's #1, so it sees the
  // result of the sample queued one clock earlier.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (armed !== e.armed || fault !== e.fault || flash_red !== e.fault ||
            fault_code !== e.code || cycles_done !== e.cyc) begin
          errors++;
          $display("FAIL %s: got armed=%0b fault=%0b flash=%0b code=%0d cyc=%0d, want armed=%0b fault=%0b flash=%0b code=%0d cyc=%0d",
                   e.tag, armed, fault, flash_red, fault_code, cycles_done,
                   e.armed, e.fault, e.fault, e.code, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    phase = "reset";
    step(LR, LR, 1, 0, 0, 0, 0, 2);

    // Legal cycles; arming happens on the first sample
    phase = "legal";
    for (int k = 0; k < 3; k++) begin
      step(LG, LR, 0, 0, 1, 0, 0, 6);
      step(LY, LR, 0, 0, 1, 0, 0, 1);
      exp_cyc = exp_cyc + 16'd1;          // highway Y->R on next sample
      step(LR, LG, 0, 0, 1, 0, 0, 5);
      step(LR, LY, 0, 0, 1, 0, 0, 1);
    end

    // fault_clr in RUN is ignored; country Y->R with highway R->G is legal
    phase = "clr_in_run";
    step(LG, LR, 0, 1, 1, 0, 0);

    // Conflict, then hold through 20 legal samples
    phase = "conflict";
    step(LG, LG, 0, 0, 0, 1, 4'd1);
    phase = "conflict_hold";
    step(LR, LR, 0, 0, 0, 1, 4'd1, 20);
    phase = "clear1";
    step(LR, LR, 0, 1, 0, 0, 0);

    // Short green
    phase = "rearm1";
    step(LR, LR, 0, 0, 1, 0, 0);
    phase = "short_green";
    step(LG, LR, 0, 0, 1, 0, 0, 2);
    step(LY, LR, 0, 0, 0, 1, 4'd6);
    phase = "clear2";
    step(LR, LR, 0, 1, 0, 0, 0);
    phase = "rearm2";
    step(LR, LR, 0, 0, 1, 0, 0);

    // Long country yellow: 5th Y sample trips
    phase = "long_yellow";
    step(LR, LG, 0, 0, 1, 0, 0, 4);
    step(LR, LY, 0, 0, 1, 0, 0, 4);
    step(LR, LY, 0, 0, 0, 1, 4'd9);
    phase = "clear3";
    step(LR, LR, 0, 1, 0, 0, 0);
    phase = "rearm3";
    step(LR, LR, 0, 0, 1, 0, 0);

    // BAD highway plus illegal country R->Y: code 2 beats code 5
    phase = "priority";
    step(LBAD, LY, 0, 0, 0, 1, 4'd2);
    phase = "clear4";
    step(LR, LR, 0, 1, 0, 0, 0);
    phase = "rearm4";
    step(LR, LR, 0, 0, 1, 0, 0);

    // Highway G->R directly, then reset the cycle after
    phase = "illegal_order";
    step(LG, LR, 0, 0, 1, 0, 0, 4);
    step(LR, LR, 0, 0, 0, 1, 4'd4);
    phase = "reset_mid";
    exp_cyc = 16'd0;
    step(LR, LR, 1, 0, 0, 0, 0);
    phase = "rearm5";
    step(LR, LR, 0, 0, 1, 0, 0);

    // Long green: only a fault when the stuck check is built in
    phase = "long_green";
    for (int i = 1; i <= 70; i++) begin
`ifdef MON_STUCK_EN
      if (i >= 65) step(LG, LR, 0, 0, 0, 1, 4'd13);
      else         step(LG, LR, 0, 0, 1, 0, 0);
`else
      step(LG, LR, 0, 0, 1, 0, 0);
`endif
    end

    // Drain the scoreboard with a bound
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlc_lamp_monitor.md
Name: tlc_lamp_monitor

Overview:
- Conflict monitor at the lamp side of the traffic light controller.
- Samples the six lamp drives (highway Gh/Yh/Rh, country Gc/Yc/Rc) each clock and checks them against the legal lamp protocol: one-hot lamps, no conflicting right-of-way, G->Y->R->G order, and minimum/maximum dwell times.
- On the first violation it latches a fault code and asserts flash_red, which the top level uses to override the lamps to all-red flashing. The latch holds until reset or an explicit clear.

Parameters:
- MIN_GREEN, 4, minimum cycles a green must be held before going yellow.
- MIN_YELLOW, 1, minimum cycles a yellow must be held.
- MAX_YELLOW, 4, maximum cycles a yellow may be held.
- ALL_RED_MIN, 0, minimum cycles the other approach must stay red after an approach's Y->R. 0 disables this check.
- MAX_GREEN, 64, green timeout; used only with MON_STUCK_EN.
- CNT_W, 8, width of the dwell counters; they saturate at 2^CNT_W-1.

Ports:
- clk  in  1  system clock, shared with the controller.
- reset  in  1  synchronous, active-high.
- Gh  in  1  highway green lamp.
- Yh  in  1  highway yellow lamp.
- Rh  in  1  highway red lamp.
- Gc  in  1  country green lamp.
- Yc  in  1  country yellow lamp.
- Rc  in  1  country red lamp.
- fault_clr  in  1  one-cycle pulse that clears a latched fault and re-arms the monitor.
- armed  out  1  high while the monitor is in RUN.
- fault  out  1  latched fault flag.
- fault_code  out  4  code of the first fault detected; 0 when no fault.
- flash_red  out  1  lamp override request; equals fault.
- cycles_done  out  16  count of completed highway cycles (highway Y->R transitions); wraps 0xFFFF->0.

Behaviour:
- Reset: on reset, all outputs go to 0, the FSM goes to ARM, and the dwell counters clear.
- Clocking: lamp inputs are synchronous to clk and sampled every posedge. All outputs are registered, so fault appears one cycle after the offending sample.
- Per-approach decode: each lamp triple decodes to R, G, Y or BAD (not one-hot).
- Dwell counters: one per approach. Resets to 1 when that approach's lamp changes, otherwise increments and saturates.
- Monitor FSM:
  - ARM: waits for a sample with both triples one-hot and at least one approach R. On that sample, captures both lamp states, clears the counters and goes to RUN (armed=1). The minimum-dwell checks for the first captured interval are suppressed; maximum checks stay active.
  - RUN: every sample is checked. On any violation, goes to FAULT and loads fault_code; fault and flash_red go to 1.
  - FAULT: holds fault_code and flash_red. No further detection takes place. cycles_done is frozen.
  - Exit from FAULT: fault_clr goes to ARM and clears fault and fault_code. fault_clr in ARM or RUN has no effect.
- Violations and codes (when several occur in the same sample, the lowest code wins):
  - 1: conflict, both approaches not R.
  - 2 / 3: highway / country triple BAD.
  - 4 / 5: highway / country illegal transition. The only legal changes are R->G, G->Y and Y->R.
  - 6 / 7: highway / country G->Y with dwell < MIN_GREEN.
  - 8 / 9: highway / country yellow dwell exceeds MAX_YELLOW. Flagged on the sample where the counter reaches MAX_YELLOW+1.
  - 10 / 11: highway / country Y->R with dwell < MIN_YELLOW.
  - 12: all-red violation. An approach goes R->G fewer than ALL_RED_MIN cycles after the other went Y->R. Only checked when ALL_RED_MIN>0.
- Simultaneous events:
  - Country Y->R and highway R->G in the same sample is legal when ALL_RED_MIN=0.
  - reset beats fault_clr; fault_clr beats a new violation in the same cycle.
- Reset mid-operation always returns to ARM, with cycles_done=0.

Optional Feature:
- Macro: MON_STUCK_EN.
- Defined: a green whose dwell reaches MAX_GREEN+1 raises code 13 (highway) or 14 (country). This is the lowest priority.
- Undefined: green hold time is unbounded (demand-driven controllers may hold highway green indefinitely) and codes 13/14 never occur.

Test Plan:
- Legal sequence: reset, then highway G 6 cycles, Y 1, R with country G 5, Y 1, then back to highway G, repeated 3 times -> fault=0 throughout, armed=1 from cycle 2, cycles_done=3.
- Conflict: in RUN, drive Gh=1,Rh=0 and Gc=1,Rc=0 for one cycle -> next cycle fault=1, fault_code=1, flash_red=1; these hold for 20 cycles despite legal lamps.
- Short green: in RUN, highway G for 2 cycles then Y -> fault_code=6. Then pulse fault_clr -> fault=0, armed=0; after the next legal sample armed=1.
- Long yellow and priority:
  - Country Y held 5 cycles -> fault_code=9 on the 5th Y sample +1.
  - Separately, a sample with Yh=1,Rh=1 (BAD) together with an illegal country R->Y -> fault_code=2 (the lower code wins).
- Illegal order and reset: highway G->R directly -> fault_code=4. Asserting reset the cycle after -> all outputs 0, ARM state.
- MON_STUCK_EN defined, MAX_GREEN=64: highway G held 70 cycles -> fault_code=13 when the dwell reaches 65. Undefined: same stimulus -> fault=0.
